// File: rtl/ex_stage.sv
// Execute stage: captures one decoded instruction per valid/allowin handshake and
// computes the ALU result combinationally. DIV/MOD ops use a DATA_W-step restoring divider.
module ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              id_to_ex_valid,
   output logic              ex_allowin,
   input  logic [31:0]       id_pc,
   input  logic [3:0]        id_alu_op,
   input  logic [DATA_W-1:0] id_src1,
   input  logic [DATA_W-1:0] id_src2,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_gr_we,
   input  logic              mem_allowin,
   output logic              ex_to_mem_valid,
   output logic [31:0]       ex_pc,
   output logic [DATA_W-1:0] ex_result,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_gr_we,
   output logic              ex_busy
);

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_SLL, OP_SRL, OP_SRA, OP_LU12I, OP_DIV, OP_MOD, OP_DIVU, OP_MODU
   } alu_op_e;

   typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

   logic              valid_q;
   logic [31:0]       pc_q;
   alu_op_e           op_q;
   logic [DATA_W-1:0] src1_q;
   logic [DATA_W-1:0] src2_q;
   logic [REG_AW-1:0] dest_q;
   logic              gr_we_q;

   div_state_e        div_state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] divisor_q;
   logic [DATA_W-1:0] res_q;
   logic              div0_q;

   logic              is_div;
   logic              div_signed;
   logic              src1_neg;
   logic              src2_neg;
   logic [DATA_W-1:0] abs1;
   logic [DATA_W-1:0] abs2;
   logic              ready_go;

   assign is_div     = (op_q[3:2] == 2'b11);
   assign div_signed = !op_q[1];
   assign src1_neg   = div_signed & src1_q[DATA_W-1];
   assign src2_neg   = div_signed & src2_q[DATA_W-1];
   assign abs1       = src1_neg ? -src1_q : src1_q;
   assign abs2       = src2_neg ? -src2_q : src2_q;

   assign ready_go        = !is_div | (div_state_q == DIV_DONE);
   assign ex_allowin      = !valid_q | (ready_go & mem_allowin);
   assign ex_to_mem_valid = valid_q & ready_go & !flush;
   assign ex_pc           = pc_q;
   assign ex_dest         = dest_q;
   assign ex_gr_we        = gr_we_q & valid_q;
   assign ex_busy         = (div_state_q != DIV_IDLE);

   // One restoring step: the remainder gets one spare bit so the shifted value never overflows.
   logic [DATA_W:0]   rem_shift;
   logic              rem_ge;
   logic [DATA_W-1:0] rem_step;
   logic [DATA_W-1:0] quo_step;

   assign rem_shift = {rem_q, quo_q[DATA_W-1]};
   assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
   assign rem_step  = rem_ge ? (rem_shift[DATA_W-1:0] - divisor_q) : rem_shift[DATA_W-1:0];
   assign quo_step  = {quo_q[DATA_W-2:0], rem_ge};

   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;
   logic [DATA_W-1:0] div_res_d;

   always_comb begin
      quo_fix = (src1_neg ^ src2_neg) ? -quo_step : quo_step;
      rem_fix = src1_neg ? -rem_step : rem_step;
      if (div0_q) begin
         quo_fix = '1;
         rem_fix = src1_q;
      end
      div_res_d = op_q[0] ? rem_fix : quo_fix;
   end

   logic [DATA_W-1:0] alu_res;

   always_comb begin
      // NOTE: default assignment first so no path through this block leaves alu_res unassigned (no latch).
      alu_res = res_q;
      case (op_q)
         OP_ADD:   alu_res = src1_q + src2_q;
         OP_SUB:   alu_res = src1_q - src2_q;
         OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
         OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, src1_q < src2_q};
         OP_AND:   alu_res = src1_q & src2_q;
         OP_OR:    alu_res = src1_q | src2_q;
         OP_XOR:   alu_res = src1_q ^ src2_q;
         OP_NOR:   alu_res = ~(src1_q | src2_q);
         OP_SLL:   alu_res = src1_q << src2_q[CNT_W-1:0];
         OP_SRL:   alu_res = src1_q >> src2_q[CNT_W-1:0];
         OP_SRA:   alu_res = $unsigned($signed(src1_q) >>> src2_q[CNT_W-1:0]);
         OP_LU12I: alu_res = src2_q;
         default:  alu_res = res_q;
      endcase
   end

   assign ex_result = alu_res;

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         op_q        <= OP_ADD;
         src1_q      <= '0;
         src2_q      <= '0;
         dest_q      <= '0;
         gr_we_q     <= 1'b0;
         div_state_q <= DIV_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         divisor_q   <= '0;
         res_q       <= '0;
         div0_q      <= 1'b0;
      end else if (flush) begin
         // Kill wins over capture; latched fields are intentionally left alone.
         valid_q     <= 1'b0;
         div_state_q <= DIV_IDLE;
         cnt_q       <= '0;
      end else begin
         if (ex_allowin) begin
            valid_q <= id_to_ex_valid;
            if (id_to_ex_valid) begin
               pc_q    <= id_pc;
               op_q    <= alu_op_e'(id_alu_op);
               src1_q  <= id_src1;
               src2_q  <= id_src2;
               dest_q  <= id_dest;
               gr_we_q <= id_gr_we;
            end
         end
         case (div_state_q)
            DIV_IDLE: begin
               if (valid_q && is_div) begin
                  quo_q       <= abs1;
                  divisor_q   <= abs2;
                  rem_q       <= '0;
                  div0_q      <= (src2_q == '0);
                  cnt_q       <= CNT_W'(DATA_W - 1);
                  div_state_q <= DIV_CALC;
               end
            end
            DIV_CALC: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               if (cnt_q == '0) begin
                  res_q       <= div_res_d;
                  div_state_q <= DIV_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DIV_DONE: begin
               if (mem_allowin) div_state_q <= DIV_IDLE;
            end
            default: div_state_q <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes expected results on capture and the
// monitor checks handshake, latency and data every cycle against that queue.
module tb_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        id_to_ex_valid;
   logic        ex_allowin;
   logic [31:0] id_pc;
   logic [3:0]  id_alu_op;
   logic [31:0] id_src1;
   logic [31:0] id_src2;
   logic [4:0]  id_dest;
   logic        id_gr_we;
   logic        mem_allowin;
   logic        ex_to_mem_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_result;
   logic [4:0]  ex_dest;
   logic        ex_gr_we;
   logic        ex_busy;

   ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .id_to_ex_valid (id_to_ex_valid),
      .ex_allowin     (ex_allowin),
      .id_pc          (id_pc),
      .id_alu_op      (id_alu_op),
      .id_src1        (id_src1),
      .id_src2        (id_src2),
      .id_dest        (id_dest),
      .id_gr_we       (id_gr_we),
      .mem_allowin    (mem_allowin),
      .ex_to_mem_valid(ex_to_mem_valid),
      .ex_pc          (ex_pc),
      .ex_result      (ex_result),
      .ex_dest        (ex_dest),
      .ex_gr_we       (ex_gr_we),
      .ex_busy        (ex_busy)
   );

   typedef struct {
      logic [31:0] res;
      logic [31:0] pc;
      logic [4:0]  dest;
      logic        we;
      logic        is_div;
      int          cap;  // cycle 0 of the instruction
      int          rdy;  // first cycle its result is presented
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   mon_en   = 0;
   bit   rand_mem = 0;
   logic mem_hold = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV truncating division already gives the
   // remainder the dividend's sign, and -2^31 / -1 = 2^31 truncates to 0x80000000.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      int unsigned sh;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      sh = b[4:0];
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return a ^ b;
         4'd7:  return ~(a | b);
         4'd8:  return a << sh;
         4'd9:  return a >> sh;
         4'd10: return 32'(sa >>> sh);
         4'd11: return b;
         4'd12: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         4'd13: return (b == 0) ? a : 32'(sa % sb);
         4'd14: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 15);
         default: return $urandom();
      endcase
   endfunction

   // Backpressure source: random or held, applied just after each rising edge.
   initial begin
      mem_allowin = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         mem_allowin = rand_mem ? ($urandom_range(0, 9) < 7) : mem_hold;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the capture edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic do_flush, output int waits);
      exp_t e;
      id_pc          = $urandom() & 32'hFFFF_FFFC;
      id_alu_op      = op;
      id_src1        = a;
      id_src2        = b;
      id_dest        = 5'($urandom_range(0, 31));
      id_gr_we       = 1'($urandom_range(0, 1));
      id_to_ex_valid = 1'b1;
      flush          = do_flush;
      waits = 0;
      forever begin
         @(negedge clk);
         #1;
         if (ex_allowin) break;
         waits++;
         if (waits > 100) begin
            check("issue_timeout", {31'b0, ex_allowin}, 32'd1);
            break;
         end
      end
      if (do_flush) begin
         sb_q.delete();
      end else if (ex_allowin) begin
         e.res    = exp_res;
         e.pc     = id_pc;
         e.dest   = id_dest;
         e.we     = id_gr_we;
         e.is_div = (op >= 4'd12);
         e.cap    = cyc + 1;
         e.rdy    = e.is_div ? e.cap + 33 : e.cap;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      id_to_ex_valid = 1'b0;
      flush          = 1'b0;
   endtask

   task automatic flush_cycle();
      flush = 1'b1;
      @(negedge clk);
      #1;
      sb_q.delete();
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle, derive the expected handshake from the scoreboard head.
   initial begin
      exp_t f;
      bit   rdy;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (sb_q.size() == 0) begin
               check("idle_valid",   {31'b0, ex_to_mem_valid}, 32'd0);
               check("idle_allowin", {31'b0, ex_allowin},      32'd1);
               check("idle_busy",    {31'b0, ex_busy},         32'd0);
               check("idle_gr_we",   {31'b0, ex_gr_we},        32'd0);
            end else begin
               f   = sb_q[0];
               rdy = (cyc >= f.rdy);
               check("valid",   {31'b0, ex_to_mem_valid}, {31'b0, rdy && !flush});
               check("allowin", {31'b0, ex_allowin},      {31'b0, rdy && mem_allowin});
               check("busy",    {31'b0, ex_busy},         {31'b0, f.is_div && (cyc > f.cap)});
               check("gr_we",   {31'b0, ex_gr_we},        {31'b0, f.we});
               if (rdy && !flush) begin
                  check("result", ex_result, f.res);
                  check("pc",     ex_pc,     f.pc);
                  check("dest",   {27'b0, ex_dest}, {27'b0, f.dest});
                  if (mem_allowin) void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int k;
      logic [3:0]  op;
      logic [31:0] a, b;

      rst_n = 1'b0; flush = 1'b0; id_to_ex_valid = 1'b0;
      id_pc = '0; id_alu_op = '0; id_src1 = '0; id_src2 = '0; id_dest = '0; id_gr_we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      #1;
      check("rst_result", ex_result, 32'h0);
      check("rst_pc",     ex_pc,     32'h0);
      check("rst_dest",   {27'b0, ex_dest}, 32'h0);
      idle(1);

      // Back-to-back ALU ops, one accepted per cycle.
      issue(4'd0,  32'hFFFF_FFFF, 32'h1, 32'h0,         1'b0, w); check("b2b_add",  w, 0);
      issue(4'd10, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, w); check("b2b_sra",  w, 0);
      issue(4'd2,  32'hFFFF_FFFF, 32'h1, 32'h1,         1'b0, w); check("b2b_slt",  w, 0);
      issue(4'd3,  32'hFFFF_FFFF, 32'h1, 32'h0,         1'b0, w); check("b2b_sltu", w, 0);
      idle(2);

      // Divider results, including divide-by-zero and signed overflow.
      issue(4'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, w);
      issue(4'd13, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, w);
      issue(4'd14, 32'd100,       32'd7,         32'd14,        1'b0, w);
      issue(4'd14, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, w);
      issue(4'd15, 32'd5,         32'd0,         32'd5,         1'b0, w);
      issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, w);
      issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, w);
      issue(4'd13, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, w);

      // Hold a finished divide for 5 cycles, then release with an instruction waiting.
      idle(40);
      mem_hold = 1'b0;
      issue(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, w);
      k = 0;
      forever begin
         @(negedge clk);
         if (ex_to_mem_valid) break;
         k++;
         if (k > 60) begin
            check("stall_wait", {31'b0, ex_to_mem_valid}, 32'd1);
            break;
         end
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      mem_hold = 1'b1;
      issue(4'd5, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, w);
      check("release_accept", w, 0);
      idle(2);

      // Flush a divide in CALC cycle 10.
      issue(4'd14, 32'd1000, 32'd3, 32'd333, 1'b0, w);
      idle(10);
      flush_cycle();
      @(negedge clk);
      #1;
      check("flush_busy",    {31'b0, ex_busy},    32'd0);
      check("flush_allowin", {31'b0, ex_allowin}, 32'd1);
      idle(1);

      // Flush on a capture edge, from empty and with a ready instruction in EX.
      issue(4'd0, 32'd1, 32'd2, 32'd3, 1'b1, w);
      idle(1);
      issue(4'd0, 32'd4, 32'd5, 32'd9, 1'b0, w);
      issue(4'd1, 32'd9, 32'd5, 32'd4, 1'b1, w);
      idle(2);

      // Randomized traffic against the reference model.
      rand_mem = 1;
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 99);
         if (k < 8) begin
            idle($urandom_range(1, 3));
         end else if (k < 12) begin
            flush_cycle();
         end else begin
            op = 4'($urandom_range(0, 15));
            if (op >= 4'd12 && $urandom_range(0, 1) == 1) op = 4'($urandom_range(0, 11));
            a = rand_opnd();
            b = rand_opnd();
            issue(op, a, b, model(op, a, b), 1'b0, w);
         end
      end

      rand_mem = 0;
      mem_hold = 1'b1;
      k = 0;
      while (sb_q.size() != 0 && k < 100) begin
         idle(1);
         k++;
      end
      check("drain", sb_q.size(), 0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
